// File: rtl/interp_fetch_ctrl_pkg.sv
// interp_fetch_ctrl_pkg: shared states, block geometry and output-slot window for the interpolation sequencer
package interp_fetch_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, REQ, SHIFT, RUN, DONE} state_t;
  localparam int AW = 16;
  localparam int ROWS_IN = 15;
  localparam int N_RESULTS = 48;
  localparam int RW = $clog2(ROWS_IN);
  localparam logic [7:0] SLOT_A_LO = 8'd3;
  localparam logic [7:0] SLOT_A_HI = 8'd10;
  localparam logic [7:0] SLOT_B_LO = 8'd15;
  localparam logic [7:0] SLOT_B_HI = 8'd46;
  function automatic logic slot_keep(input logic [7:0] sel);
    return (sel >= SLOT_A_LO && sel <= SLOT_A_HI) || (sel >= SLOT_B_LO && sel <= SLOT_B_HI);
  endfunction
endpackage

// File: rtl/interp_fetch_ctrl_if.sv
// interp_fetch_ctrl_if: scheduler, memory, shift-register and filter/output-filler signals of the sequencer
interface interp_fetch_ctrl_if;
  import interp_fetch_ctrl_pkg::*;
  logic start;
  logic abort;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] stride;
  logic rd_req;
  logic [AW-1:0] rd_addr;
  logic rd_valid;
  logic [63:0] rd_data;
  logic sr_load_L;
  logic [63:0] sr_data;
  logic filt_en;
  logic res_valid;
  logic [7:0] of_sel;
  logic of_load_L;
  logic busy;
  logic done;
  modport slave (
    input start, abort, base_addr, stride, rd_valid, rd_data, res_valid,
    output rd_req, rd_addr, sr_load_L, sr_data, filt_en, of_sel, of_load_L, busy, done
  );
  modport master (
    output start, abort, base_addr, stride, rd_valid, rd_data, res_valid,
    input rd_req, rd_addr, sr_load_L, sr_data, filt_en, of_sel, of_load_L, busy, done
  );
endinterface

// File: rtl/interp_addr_gen.sv
// interp_addr_gen: reference row counter and stride-accumulated read address
module interp_addr_gen
  import interp_fetch_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset_L,
  input  logic          clear,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  output logic [AW-1:0] addr,
  output logic          last_row
);
  logic [RW-1:0] row;
  logic [AW-1:0] stride_q;
  assign last_row = row == RW'(ROWS_IN - 1);
  // clear wins over a new block; each step advances one row, address wraps mod 2^AW
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      row <= '0;
      addr <= '0;
      stride_q <= '0;
    end else if (clear) begin
      row <= '0;
      addr <= '0;
    end else if (load) begin
      row <= '0;
      addr <= base_addr;
      stride_q <= stride;
    end else if (step) begin
      row <= row + RW'(1);
      addr <= addr + stride_q;
    end
endmodule

// File: rtl/interp_fetch_ctrl.sv
// interp_fetch_ctrl: fetch 15 reference rows into the shift register, then steer filter results into output-filler slots
module interp_fetch_ctrl
  import interp_fetch_ctrl_pkg::*;
(
  input logic clock,
  input logic reset_L,
  interp_fetch_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic load, step, last_row;
  logic [AW-1:0] addr;
  assign load = state == IDLE && bus.start && !bus.abort;
  assign step = state == SHIFT && !bus.abort;
  assign bus.rd_addr = addr;
  assign bus.of_load_L = !(state == RUN && bus.res_valid && slot_keep(bus.of_sel));
  interp_addr_gen u_addr (
    .clock     (clock),
    .reset_L   (reset_L),
    .clear     (bus.abort),
    .load      (load),
    .step      (step),
    .base_addr (bus.base_addr),
    .stride    (bus.stride),
    .addr      (addr),
    .last_row  (last_row)
  );
  // next state; abort overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = REQ;
      REQ:     if (bus.rd_valid) state_nx = SHIFT;
      SHIFT:   state_nx = last_row ? RUN : REQ;
      RUN:     if (bus.res_valid && bus.of_sel == 8'(N_RESULTS - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end
  // state plus outputs registered from the next state so they change cleanly on the edge
  always_ff @(posedge clock or negedge reset_L)
    if (!reset_L) begin
      state <= IDLE;
      bus.rd_req <= 1'b0;
      bus.sr_load_L <= 1'b1;
      bus.sr_data <= '0;
      bus.filt_en <= 1'b0;
      bus.of_sel <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_nx;
      bus.rd_req <= state_nx == REQ;
      bus.sr_load_L <= state_nx != SHIFT;
      bus.filt_en <= state_nx == RUN;
      bus.busy <= state_nx != IDLE;
      bus.done <= state_nx == DONE;
      if (state == REQ && bus.rd_valid && !bus.abort) bus.sr_data <= bus.rd_data;
      bus.of_sel <= (bus.abort || load || (state == SHIFT && last_row)) ? 8'd0 :
                    (state == RUN && bus.res_valid) ? bus.of_sel + 8'd1 : bus.of_sel;
    end
endmodule

// File: tb/tb_interp_fetch_ctrl.sv
// tb_interp_fetch_ctrl: scoreboard bench for the interpolation fetch sequencer
module tb_interp_fetch_ctrl;
  import interp_fetch_ctrl_pkg::*;
  logic clock = 1'b0;
  logic reset_L = 1'b0;
  interp_fetch_ctrl_if bus();
  interp_fetch_ctrl dut (.clock(clock), .reset_L(reset_L), .bus(bus));
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] addr_q[$];
  logic [63:0] sr_q[$];
  logic [7:0] sel_q[$];
  int done_q[$];
  int load_cnt = 0;
  bit mem_rand = 0;
  bit res_rand = 0;
  int wait_n = 0;
  int lat = 0;
  logic prev_req = 1'b0;
  logic [15:0] held_addr = '0;
  logic [7:0] last_acc = 8'hff;

  function automatic logic [63:0] word(input logic [15:0] a);
    return {a, ~a, a ^ 16'hA5C3, a + 16'h1234};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory: answers each request after 0 or a random 0-5 cycles
  always @(negedge clock) begin
    if (bus.rd_req) begin
      if (wait_n >= lat) begin
        bus.rd_valid = 1'b1;
        bus.rd_data = word(bus.rd_addr);
      end else begin
        bus.rd_valid = 1'b0;
        wait_n++;
      end
    end else begin
      bus.rd_valid = 1'b0;
      bus.rd_data = 64'hDEAD_BEEF_0BAD_F00D;
      wait_n = 0;
      lat = mem_rand ? int'($urandom_range(0, 5)) : 0;
    end
  end

  // filter: result every cycle or with random gaps
  always @(negedge clock)
    bus.res_valid = res_rand ? ($urandom_range(0, 2) != 0) : 1'b1;

  // monitor: pops expectations whenever the DUT presents an output
  always @(negedge clock) begin
    #2;
    if (reset_L) begin
      if (bus.rd_req) begin
        if (!prev_req) begin
          chk("addr_expected", addr_q.size() != 0, 1'b1);
          if (addr_q.size() != 0) chk("rd_addr", bus.rd_addr, addr_q.pop_front());
        end else chk("rd_addr_stable", bus.rd_addr, held_addr);
        held_addr = bus.rd_addr;
      end
      prev_req = bus.rd_req;
      if (!bus.sr_load_L) begin
        load_cnt++;
        chk("sr_load_expected", sr_q.size() != 0, 1'b1);
        if (sr_q.size() != 0) chk("sr_data", bus.sr_data, sr_q.pop_front());
      end
      if (!bus.of_load_L) begin
        chk("of_load_expected", sel_q.size() != 0, 1'b1);
        if (sel_q.size() != 0) chk("of_sel", bus.of_sel, sel_q.pop_front());
      end
      if (bus.done) begin
        chk("done_expected", done_q.size() != 0, 1'b1);
        if (done_q.size() != 0) void'(done_q.pop_front());
        chk("done_after_sel47", last_acc, 8'd47);
      end
      last_acc = (bus.filt_en && bus.res_valid) ? bus.of_sel : 8'hff;
    end else prev_req = 1'b0;
  end

  task automatic push_block(input logic [15:0] b, input logic [15:0] s, input int rows, input bit full);
    for (int k = 0; k < rows; k++) begin
      logic [15:0] a;
      a = b + 16'(k) * s;
      addr_q.push_back(a);
      if (k < rows - 1 || full) sr_q.push_back(word(a));
    end
    if (full) begin
      for (int i = 3; i <= 10; i++) sel_q.push_back(8'(i));
      for (int i = 15; i <= 46; i++) sel_q.push_back(8'(i));
      done_q.push_back(1);
    end
  endtask

  task automatic kick(input logic [15:0] b, input logic [15:0] s);
    @(negedge clock);
    bus.base_addr = b;
    bus.stride = s;
    bus.start = 1'b1;
  endtask

  task automatic wait_filt(output int n);
    n = 0;
    do begin
      @(negedge clock);
      bus.start = 1'b0;
      #2;
      n++;
    end while (!bus.filt_en && n < 1000);
  endtask

  task automatic check_empty(input string nm);
    @(negedge clock);
    #3;
    chk({nm, "_addr_left"}, addr_q.size(), 0);
    chk({nm, "_sr_left"}, sr_q.size(), 0);
    chk({nm, "_sel_left"}, sel_q.size(), 0);
    chk({nm, "_done_left"}, done_q.size(), 0);
  endtask

  task automatic run_block(input string nm, input logic [15:0] b, input logic [15:0] s, input bit rnd, input bit poke);
    int n;
    mem_rand = rnd;
    res_rand = rnd;
    push_block(b, s, ROWS_IN, 1'b1);
    kick(b, s);
    wait_filt(n);
    if (rnd) chk({nm, "_filt_en_seen"}, bus.filt_en, 1'b1);
    else chk({nm, "_filt_en_cycle"}, n, 31);
    if (poke) begin
      @(negedge clock);
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clock);
      #3;
      n++;
    end while ((done_q.size() != 0 || bus.busy) && n < 2000);
    chk({nm, "_busy_end"}, bus.busy, 1'b0);
    check_empty(nm);
  endtask

  initial begin
    int n, base_cnt;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.base_addr = '0;
    bus.stride = '0;
    #7;
    chk("rst_rd_req", bus.rd_req, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 16'h0);
    chk("rst_sr_data", bus.sr_data, 64'h0);
    chk("rst_sr_load_L", bus.sr_load_L, 1'b1);
    chk("rst_filt_en", bus.filt_en, 1'b0);
    chk("rst_of_sel", bus.of_sel, 8'h0);
    chk("rst_of_load_L", bus.of_load_L, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    @(negedge clock);
    reset_L = 1'b1;
    repeat (2) @(negedge clock);

    run_block("nominal", 16'h0100, 16'h0040, 1'b0, 1'b0);
    run_block("random", 16'h0100, 16'h0040, 1'b1, 1'b0);
    run_block("wrap", 16'hFFC0, 16'h0020, 1'b1, 1'b0);

    // abort during row 7 request with read data in the same cycle
    mem_rand = 0;
    res_rand = 0;
    push_block(16'h0100, 16'h0040, 8, 1'b0);
    base_cnt = load_cnt;
    kick(16'h0100, 16'h0040);
    n = 0;
    do begin
      @(negedge clock);
      bus.start = 1'b0;
      n++;
    end while (!(bus.rd_req && load_cnt - base_cnt == 7) && n < 500);
    chk("abort_reached_row7", load_cnt - base_cnt, 7);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    #2;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_rd_req", bus.rd_req, 1'b0);
    chk("abort_sr_load_L", bus.sr_load_L, 1'b1);
    repeat (3) @(negedge clock);
    check_empty("abort");
    chk("abort_loads", load_cnt - base_cnt, 7);
    run_block("after_abort", 16'h0100, 16'h0040, 1'b0, 1'b0);

    run_block("start_in_run", 16'h2000, 16'h0108, 1'b0, 1'b1);

    // reset mid-RUN
    push_block(16'h0100, 16'h0040, ROWS_IN, 1'b1);
    kick(16'h0100, 16'h0040);
    wait_filt(n);
    chk("mid_filt_en", bus.filt_en, 1'b1);
    repeat (10) @(negedge clock);
    reset_L = 1'b0;
    #1;
    chk("mid_rst_rd_req", bus.rd_req, 1'b0);
    chk("mid_rst_rd_addr", bus.rd_addr, 16'h0);
    chk("mid_rst_sr_data", bus.sr_data, 64'h0);
    chk("mid_rst_sr_load_L", bus.sr_load_L, 1'b1);
    chk("mid_rst_filt_en", bus.filt_en, 1'b0);
    chk("mid_rst_of_sel", bus.of_sel, 8'h0);
    chk("mid_rst_of_load_L", bus.of_load_L, 1'b1);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    addr_q.delete();
    sr_q.delete();
    sel_q.delete();
    done_q.delete();
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    run_block("after_reset", 16'h0100, 16'h0040, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/interp_fetch_ctrl.md
# interp_fetch_ctrl

Sequencer for the 8x8 sub-pixel interpolation datapath. It fetches 15 reference rows of 64 bits from block memory and pushes them into the 15-row byte shift register, one row per load. It then enables the filter and steers each filter result into the correct output-filler slot via `of_sel` and `of_load_L`. It sits between the top-level block scheduler (start/done) and the shift-register / filter / output-filler datapath.

## Interface
- `ROWS_IN`, 15: reference rows per block (8 output rows + 7 tap overhang).
- `N_RESULTS`, 48: filter results consumed per block (`of_sel` 0..47).
- `AW`, 16: memory address width.
- `clock` in 1: clock; all logic on posedge.
- `reset_L` in 1: reset, asynchronous, active-low.
- `start` in 1: begin block; sampled in IDLE only.
- `abort` in 1: synchronous cancel; returns to IDLE next cycle.
- `base_addr` in AW: address of row 0; captured on accepted start.
- `stride` in AW: row pitch; captured on accepted start.
- `rd_req` out 1: memory read request.
- `rd_addr` out AW: read address, stable while `rd_req`=1.
- `rd_valid` in 1: read data valid; completes the request.
- `rd_data` in 64: read data.
- `sr_load_L` out 1: shift-register load enable, active low.
- `sr_data` out 64: registered copy of `rd_data`.
- `filt_en` out 1: filter enable.
- `res_valid` in 1: filter result available this cycle.
- `of_sel` out 8: output-filler slot index.
- `of_load_L` out 1: output-filler load enable, active low.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, REQ, SHIFT, RUN, DONE.
- IDLE, start=1: capture `base_addr`/`stride`, row=0, addr=base_addr → REQ.
- REQ: `rd_req`=1, `rd_addr`=addr. On `rd_valid`: latch `rd_data` into `sr_data` → SHIFT. `rd_valid` outside REQ is ignored.
- SHIFT: `sr_load_L`=0 for exactly one cycle; row+=1; addr+=stride, wrapping mod 2^AW.
  - If row was `ROWS_IN`-1 → RUN, with `of_sel`=0.
  - Else → REQ.
- RUN: `filt_en`=1. Each cycle with `res_valid`=1:
  - `of_load_L`=0 combinationally iff `of_sel` ∈ [3,10] or [15,46]; otherwise `of_load_L`=1 (warm-up/boundary results are discarded).
  - `of_sel` increments.
  - A result accepted at `of_sel`=`N_RESULTS`-1 → DONE.
- DONE: `done`=1 for one cycle → IDLE. `of_sel` holds its final value until the next start.
- `abort` overrides every transition: → IDLE. Row, addr and `of_sel` clear; `rd_req`, `filt_en` and `sr_load_L` deassert on the next edge. A `rd_valid` in the same cycle as `abort` is dropped.
- start while busy: ignored, no queueing.
- start and abort in the same cycle in IDLE: abort wins; stays IDLE.

## Timing
- Reset values:
  - State=IDLE.
  - `rd_req`=0, `rd_addr`=0, `sr_data`=0, `sr_load_L`=1.
  - `filt_en`=0, `of_sel`=0, `of_load_L`=1, `busy`=0, `done`=0.
- `rd_req` rises the cycle after start is accepted.
- `rd_valid` may arrive in the same cycle `rd_req` first rises (zero-wait memory). Per-row cost is then 2 cycles (REQ + SHIFT), so 15 rows take 30 cycles minimum.
- `sr_data` is valid on the same cycle as `sr_load_L`=0 and stays stable until the next capture.
- `filt_en` rises the cycle after the last SHIFT.
- `res_valid` may be high every RUN cycle.
- `done` is asserted on the cycle after the 48th result.
- All outputs are registered except `of_load_L`, which is a decode of the `res_valid` input and registered `of_sel`.
- reset_L mid-block: immediate return to reset values; no completion pulse.

## Structure
- Shared package holds:
  - State enum.
  - `ROWS_IN`, `N_RESULTS`.
  - Slot window constants (3, 10, 15, 46).
- One sub-module, `interp_addr_gen`: row counter plus stride accumulator with clear/step/last_row outputs.
- The FSM and output-select logic stay in `interp_fetch_ctrl`.

## Test plan
- Nominal block, zero-wait memory, base=0x0100, stride=0x0040:
  - Addresses 0x0100, 0x0140 … 0x0480 appear in order.
  - 15 `sr_load_L` pulses, each `sr_data` equal to the returned word.
  - `filt_en` rises on cycle 31 after start.
- RUN phase, `res_valid` held high:
  - 40 `of_load_L` pulses, at `of_sel` 3–10 and 15–46.
  - `done` on the cycle after `of_sel`=47; `busy` drops with it.
- Random 0–5 cycle memory latency and random `res_valid` gaps: identical address sequence, load count and slot sequence as the zero-wait run.
- Wrap case, base=0xFFC0, stride=0x0020: addresses 0xFFC0, 0xFFE0, 0x0000 …, with no carry beyond 16 bits.
- abort during REQ at row 7 with `rd_valid` in the same cycle:
  - IDLE next cycle; no `sr_load_L` pulse; no `done`.
  - A following start fetches from row 0 again.
- start pulsed during RUN: no effect on counts. reset_L low mid-RUN: all outputs at reset values asynchronously.
